// File: rtl/dual_issue_queue_pkg.sv
// riscv_issue_pkg: shared opcode constants, instruction class enum and the
// opcode classifier used by the issue-stage decode-lite slices.
// No ports (package).
package riscv_issue_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ALU,
    CLS_OTHER
  } iclass_e;

  function automatic iclass_e classify(input logic [6:0] opc);
    case (opc)
      OPC_LOAD:                                 return CLS_LOAD;
      OPC_STORE:                                return CLS_STORE;
      OPC_BRANCH:                               return CLS_BRANCH;
      OPC_JAL, OPC_JALR:                        return CLS_JUMP;
      OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC:   return CLS_ALU;
      default:                                  return CLS_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/dual_issue_queue_decode.sv
// issue_decode_lite: minimal per-slot decode for issue legality checks.
// Ports:
//   instr     in  32 - instruction word
//   rd/rs1/rs2 out 5 - register fields
//   uses_rs1, uses_rs2, writes_rd - operand usage (writes_rd false for x0)
//   is_mem, is_load, is_ctrl       - memory port / load / control transfer
module issue_decode_lite
  import riscv_issue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd,
  output logic        is_mem,
  output logic        is_load,
  output logic        is_ctrl
);

  iclass_e    cls;
  logic [6:0] opc;

  always_comb begin
    opc       = instr[6:0];
    cls       = classify(opc);
    rd        = instr[11:7];
    rs1       = instr[19:15];
    rs2       = instr[24:20];
    uses_rs1  = opc inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
    uses_rs2  = opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    // Unknown opcodes fall into CLS_OTHER and write nothing.
    writes_rd = (cls inside {CLS_LOAD, CLS_JUMP, CLS_ALU}) && (instr[11:7] != 5'd0);
    is_mem    = (cls == CLS_LOAD) || (cls == CLS_STORE);
    is_load   = (cls == CLS_LOAD);
    is_ctrl   = (cls == CLS_BRANCH) || (cls == CLS_JUMP);
  end

endmodule

// File: rtl/dual_issue_queue.sv
// dual_issue_queue: circular instruction queue feeding an in-order issue
// stage. Each cycle the longest legal prefix of up to ISSUE_W head entries
// issues, subject to intra-group pairing rules and a load-use scoreboard.
// Optional statistics counters are enabled with the ISSUE_STATS_EN macro.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_instr/in_pc, in_ready      - fetch group enqueue
//   iss_valid/iss_instr/iss_pc, iss_ready  - issued group (combinational)
//   flush                                  - empties the queue
//   ld_wb_en/ld_wb_rd                      - load writeback, clears scoreboard
//   stat_bubble/stat_split/stat_ld_stall   - only with ISSUE_STATS_EN
module dual_issue_queue
  import riscv_issue_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int PC_W    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ISSUE_W-1:0]      in_valid,
  input  logic [32*ISSUE_W-1:0]   in_instr,
  input  logic [PC_W-1:0]         in_pc,
  output logic                    in_ready,
  output logic [ISSUE_W-1:0]      iss_valid,
  output logic [32*ISSUE_W-1:0]   iss_instr,
  output logic [PC_W*ISSUE_W-1:0] iss_pc,
  input  logic                    iss_ready,
  input  logic                    flush,
  input  logic [ISSUE_W-1:0]      ld_wb_en,
  input  logic [5*ISSUE_W-1:0]    ld_wb_rd
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]             stat_bubble,
  output logic [31:0]             stat_split,
  output logic [31:0]             stat_ld_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      sb_q, sb_d;

  logic [31:0]      slot_instr [ISSUE_W];
  logic [PC_W-1:0]  slot_pc    [ISSUE_W];
  logic [4:0]       dec_rd [ISSUE_W], dec_rs1 [ISSUE_W], dec_rs2 [ISSUE_W];
  logic [ISSUE_W-1:0] dec_u1, dec_u2, dec_wr, dec_mem, dec_ld, dec_ctrl;

  logic [ISSUE_W-1:0] iss_ok, exists, pair_blk, sb_hit;
  logic [CNT_W-1:0]   n_enq, n_deq;
  logic               enq_fire, split_evt;

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
    assign slot_instr[k] = instr_mem[head_q + PTR_W'(k)];
    assign slot_pc[k]    = pc_mem[head_q + PTR_W'(k)];

    issue_decode_lite u_dec (
      .instr     (slot_instr[k]),
      .rd        (dec_rd[k]),
      .rs1       (dec_rs1[k]),
      .rs2       (dec_rs2[k]),
      .uses_rs1  (dec_u1[k]),
      .uses_rs2  (dec_u2[k]),
      .writes_rd (dec_wr[k]),
      .is_mem    (dec_mem[k]),
      .is_load   (dec_ld[k]),
      .is_ctrl   (dec_ctrl[k])
    );
  end

  // Issue selection: walk the slots in order; the first blocked slot stops the group.
  always_comb begin
    logic [31:0] grp_wr;
    logic        grp_mem, grp_ctrl, prev_ok, raw;
    grp_wr    = '0;
    grp_mem   = 1'b0;
    grp_ctrl  = 1'b0;
    prev_ok   = iss_ready && !flush && !rst;
    iss_ok    = '0;
    exists    = '0;
    pair_blk  = '0;
    sb_hit    = '0;
    split_evt = 1'b0;
    raw       = 1'b0;
    for (int k = 0; k < ISSUE_W; k++) begin
      exists[k]   = count_q > CNT_W'(k);
      sb_hit[k]   = (dec_u1[k] && sb_q[dec_rs1[k]]) || (dec_u2[k] && sb_q[dec_rs2[k]]);
      raw         = (dec_u1[k] && grp_wr[dec_rs1[k]]) || (dec_u2[k] && grp_wr[dec_rs2[k]]);
      pair_blk[k] = raw || (dec_mem[k] && grp_mem) || grp_ctrl;
      if (k > 0 && prev_ok && exists[k] && pair_blk[k]) split_evt = 1'b1;
      iss_ok[k]   = prev_ok && exists[k] && !pair_blk[k] && !sb_hit[k];
      prev_ok     = iss_ok[k];
      if (dec_wr[k]) grp_wr[dec_rd[k]] = 1'b1;
      grp_mem  = grp_mem  || dec_mem[k];
      grp_ctrl = grp_ctrl || dec_ctrl[k];
    end
  end

  always_comb begin
    iss_valid = iss_ok;
    iss_instr = '0;
    iss_pc    = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (iss_ok[k]) begin
        iss_instr[32*k +: 32]     = slot_instr[k];
        iss_pc[PC_W*k +: PC_W]    = slot_pc[k];
      end
    end
  end

  // No combinational path from iss_ready: readiness looks at the current count only.
  assign in_ready = !rst && (count_q <= CNT_W'(DEPTH - ISSUE_W));
  assign enq_fire = in_ready && in_valid[0] && !flush;

  always_comb begin
    n_enq = '0;
    n_deq = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      n_enq = n_enq + CNT_W'(in_valid[k]);
      n_deq = n_deq + CNT_W'(iss_ok[k]);
    end
    head_d  = head_q + PTR_W'(n_deq);
    tail_d  = enq_fire ? tail_q + PTR_W'(n_enq) : tail_q;
    count_d = count_q + (enq_fire ? n_enq : '0) - n_deq;
    if (flush) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end
    // Clears first, then sets, so a same-cycle set of the same register wins.
    sb_d = sb_q;
    for (int k = 0; k < ISSUE_W; k++)
      if (ld_wb_en[k]) sb_d[ld_wb_rd[5*k +: 5]] = 1'b0;
    for (int k = 0; k < ISSUE_W; k++)
      if (iss_ok[k] && dec_ld[k] && dec_wr[k]) sb_d[dec_rd[k]] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Queue storage: data only, no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ISSUE_W; k++) begin
      if (enq_fire && in_valid[k]) begin
        instr_mem[tail_q + PTR_W'(k)] <= in_instr[32*k +: 32];
        pc_mem[tail_q + PTR_W'(k)]    <= in_pc + PC_W'(4 * k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      sb_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      sb_q    <= sb_d;
    end
  end

`ifdef ISSUE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] stat_bubble_q, stat_bubble_d;
  logic [31:0] stat_split_q, stat_split_d;
  logic [31:0] stat_ld_stall_q, stat_ld_stall_d;

  always_comb begin
    stat_bubble_d   = sat_inc(stat_bubble_q, (count_q != '0) && (iss_ok == '0));
    stat_split_d    = sat_inc(stat_split_q, split_evt);
    stat_ld_stall_d = sat_inc(stat_ld_stall_q, exists[0] && sb_hit[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bubble_q   <= '0;
      stat_split_q    <= '0;
      stat_ld_stall_q <= '0;
    end else begin
      stat_bubble_q   <= stat_bubble_d;
      stat_split_q    <= stat_split_d;
      stat_ld_stall_q <= stat_ld_stall_d;
    end
  end

  assign stat_bubble   = stat_bubble_q;
  assign stat_split    = stat_split_q;
  assign stat_ld_stall = stat_ld_stall_q;
`else
  logic unused_stats;
  assign unused_stats = split_evt;
`endif

endmodule
